// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared CPU package: opcodes, pipeline-control states, divider default
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_DIV_WAIT = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_FLUSH    = 2'd3
  } pipe_state_t;

  localparam int DIV_CYCLES_DEF = 32;
  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2b;
  localparam logic [5:0] FN_MFHI    = 6'h10;
  localparam logic [5:0] FN_MFLO    = 6'h12;
  localparam logic [5:0] FN_MULT    = 6'h18;
  localparam logic [5:0] FN_DIV     = 6'h1a;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// rtl/pipe_ctrl_hazard_detect.sv - combinational load-use and HI/LO interlock compare
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_use_rs,
  input  logic       id_use_rt,
  input  logic       id_use_hilo,
  input  logic [4:0] exe_reg,
  input  logic       exe_load,
  input  logic       div_busy,
  output logic       load_use,
  output logic       hilo_wait
);

  // Register zero is hardwired, so a load targeting it never creates a dependency.
  assign load_use = exe_load && (exe_reg != REG_ZERO) &&
                    ((id_use_rs && (id_rs == exe_reg)) ||
                     (id_use_rt && (id_rt == exe_reg)));

  assign hilo_wait = div_busy && id_use_hilo;

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall/flush controller with multi-cycle divide tracking
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = DIV_CYCLES_DEF,
  parameter int CNT_W      = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_use_rs,
  input  logic       id_use_rt,
  input  logic       id_use_hilo,
  input  logic [4:0] exe_reg,
  input  logic       exe_load,
  input  logic       div_start,
  input  logic       dmem_req,
  input  logic       dmem_ack,
  input  logic       exc_req,
  output logic       stall_if,
  output logic       stall_id,
  output logic       stall_ex,
  output logic       stall_mem,
  output logic       bubble_ex,
  output logic       flush,
  output logic       div_busy,
  output logic       div_done,
  output logic [1:0] state
);

  pipe_state_t      cur_st, nxt_st;
  logic [CNT_W-1:0] cnt;
  logic             div_go;
  logic             load_use, hilo_wait;
  logic             stall_all;

  hazard_detect u_hazard (
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_use_rs   (id_use_rs),
    .id_use_rt   (id_use_rt),
    .id_use_hilo (id_use_hilo),
    .exe_reg     (exe_reg),
    .exe_load    (exe_load),
    .div_busy    (div_busy),
    .load_use    (load_use),
    .hilo_wait   (hilo_wait)
  );

  always_comb begin
    nxt_st    = cur_st;
    stall_all = 1'b0;
    bubble_ex = 1'b0;
    flush     = 1'b0;
    div_go    = 1'b0;
    if (exc_req) begin
      flush  = 1'b1;
      nxt_st = ST_FLUSH;
    end else if (cur_st == ST_FLUSH) begin
      nxt_st = ST_RUN;
    end else if (cur_st == ST_MEM_WAIT && !dmem_ack) begin
      stall_all = 1'b1;
    end else if (cur_st != ST_MEM_WAIT && dmem_req && !dmem_ack) begin
      stall_all = 1'b1;
      nxt_st    = ST_MEM_WAIT;
    end else begin
      if (cur_st == ST_MEM_WAIT)
        nxt_st = (div_busy && cnt != '0) ? ST_DIV_WAIT : ST_RUN;
      else if (cur_st == ST_DIV_WAIT && cnt == '0)
        nxt_st = ST_RUN;
      if (load_use || hilo_wait) begin
        bubble_ex = 1'b1;
      end else if (cur_st == ST_RUN && div_start) begin
        div_go = 1'b1;
        nxt_st = ST_DIV_WAIT;
      end
    end
  end

  assign stall_if  = stall_all || bubble_ex;
  assign stall_id  = stall_all || bubble_ex;
  assign stall_ex  = stall_all;
  assign stall_mem = stall_all;
  assign state     = cur_st;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_st <= ST_RUN;
    end else begin
      cur_st <= nxt_st;
    end
  end

  // div_done is raised one cycle ahead (count==1) so it lands in the cycle the count reads 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt      <= '0;
      div_busy <= 1'b0;
      div_done <= 1'b0;
    end else if (exc_req) begin
      cnt      <= '0;
      div_busy <= 1'b0;
      div_done <= 1'b0;
    end else if (div_go) begin
      cnt      <= CNT_W'(DIV_CYCLES - 1);
      div_busy <= 1'b1;
      div_done <= 1'b0;
    end else begin
      if (cnt != '0)
        cnt <= cnt - CNT_W'(1);
      div_done <= div_busy && (cnt == CNT_W'(1));
      if (div_busy && cnt == '0)
        div_busy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed self-checking bench for pipe_ctrl
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, exe_reg = '0;
  logic       id_use_rs = 0, id_use_rt = 0, id_use_hilo = 0, exe_load = 0;
  logic       div_start = 0, dmem_req = 0, dmem_ack = 0, exc_req = 0;
  logic       stall_if, stall_id, stall_ex, stall_mem, bubble_ex, flush;
  logic       div_busy, div_done;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;
  int done_cnt;

  pipe_ctrl dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_use_hilo(id_use_hilo), .exe_reg(exe_reg), .exe_load(exe_load),
    .div_start(div_start), .dmem_req(dmem_req), .dmem_ack(dmem_ack), .exc_req(exc_req),
    .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex), .stall_mem(stall_mem),
    .bubble_ex(bubble_ex), .flush(flush), .div_busy(div_busy), .div_done(div_done),
    .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] stalls();
    return {stall_if, stall_id, stall_ex, stall_mem};
  endfunction

  initial begin
    // reset state
    #12;
    chk("rst_state", 32'(state), 32'(ST_RUN));
    chk("rst_busy", 32'(div_busy), 0);
    chk("rst_done", 32'(div_done), 0);
    chk("rst_flush", 32'(flush), 0);
    chk("rst_stalls", 32'(stalls()), 0);
    chk("rst_bubble", 32'(bubble_ex), 0);
    reset = 1'b1;
    tick();

    // load-use hazard on rs
    exe_load = 1; exe_reg = 5'd5; id_rs = 5'd5; id_use_rs = 1; #2;
    chk("lu_stalls", 32'(stalls()), 32'b1100);
    chk("lu_bubble", 32'(bubble_ex), 1);
    tick();
    exe_load = 0; #2;
    chk("lu_release", 32'(stalls()), 0);
    tick();
    exe_load = 1; exe_reg = 5'd0; id_rs = 5'd0; #2;
    chk("lu_r0_stalls", 32'(stalls()), 0);
    chk("lu_r0_bubble", 32'(bubble_ex), 0);
    exe_reg = 5'd7; id_rs = 5'd1; id_rt = 5'd7; id_use_rt = 0; #2;
    chk("lu_rt_unused", 32'(bubble_ex), 0);
    id_use_rt = 1; #2;
    chk("lu_rt_used", 32'(bubble_ex), 1);
    tick();
    exe_load = 0; id_use_rs = 0; id_use_rt = 0; exe_reg = '0; id_rs = '0; id_rt = '0;

    // divide with a HI/LO reader arriving at cycle 10
    div_start = 1; #2;
    chk("div_c0_busy", 32'(div_busy), 0);
    done_cnt = 0;
    for (int c = 1; c <= 34; c++) begin
      tick();
      div_start = 0;
      id_use_hilo = (c >= 10);
      #2;
      chk($sformatf("div_c%0d_busy", c), 32'(div_busy), 32'(c <= 32));
      chk($sformatf("div_c%0d_done", c), 32'(div_done), 32'(c == 32));
      chk($sformatf("div_c%0d_stall", c), 32'(stall_id), 32'(c >= 10 && c <= 32));
      chk($sformatf("div_c%0d_bub", c), 32'(bubble_ex), 32'(c >= 10 && c <= 32));
      chk($sformatf("div_c%0d_stex", c), 32'(stall_ex), 0);
      if (c == 5) chk("div_state", 32'(state), 32'(ST_DIV_WAIT));
      if (c == 33) chk("div_end_state", 32'(state), 32'(ST_RUN));
    end
    id_use_hilo = 0;

    // memory wait, ack on cycle 4
    tick();
    dmem_req = 1; dmem_ack = 0; #2;
    chk("mem_c0_stalls", 32'(stalls()), 32'hF);
    for (int c = 1; c <= 5; c++) begin
      tick();
      dmem_ack = (c == 4);
      dmem_req = (c <= 4);
      #2;
      chk($sformatf("mem_c%0d_stalls", c), 32'(stalls()), (c <= 3) ? 32'hF : 32'h0);
      chk($sformatf("mem_c%0d_state", c), 32'(state), (c <= 4) ? 32'(ST_MEM_WAIT) : 32'(ST_RUN));
    end
    dmem_req = 0; dmem_ack = 0;

    // exception at cycle 10 of a divide
    tick();
    div_start = 1; #2;
    for (int c = 1; c <= 10; c++) begin
      tick();
      div_start = 0;
      exc_req = (c == 10);
      #2;
    end
    chk("exc_flush", 32'(flush), 1);
    chk("exc_stalls", 32'(stalls()), 0);
    tick();
    exc_req = 0; #2;
    chk("exc_state_flush", 32'(state), 32'(ST_FLUSH));
    chk("exc_busy_drop", 32'(div_busy), 0);
    chk("exc_flush_off", 32'(flush), 0);
    chk("exc_flush_stalls", 32'(stalls()), 0);
    tick(); #2;
    chk("exc_state_run", 32'(state), 32'(ST_RUN));
    done_cnt = 0;
    for (int c = 0; c < 30; c++) begin
      if (div_done) done_cnt++;
      tick(); #2;
    end
    chk("exc_no_done", 32'(done_cnt), 0);

    // divide with MEM_WAIT spanning the counter reaching zero
    div_start = 1; #2;
    for (int c = 1; c <= 36; c++) begin
      tick();
      div_start = 0;
      dmem_req = (c >= 28 && c <= 35);
      dmem_ack = (c == 35);
      #2;
      chk($sformatf("dm_c%0d_done", c), 32'(div_done), 32'(c == 32));
      chk($sformatf("dm_c%0d_busy", c), 32'(div_busy), 32'(c <= 32));
      if (c >= 28) chk($sformatf("dm_c%0d_stex", c), 32'(stall_ex), 32'(c <= 34));
      if (c >= 29 && c <= 35) chk($sformatf("dm_c%0d_state", c), 32'(state), 32'(ST_MEM_WAIT));
    end
    chk("dm_end_state", 32'(state), 32'(ST_RUN));
    dmem_req = 0; dmem_ack = 0;

    // asynchronous reset mid-divide
    tick();
    div_start = 1; #2;
    for (int c = 1; c <= 5; c++) begin
      tick();
      div_start = 0;
    end
    #1;
    chk("ar_pre_busy", 32'(div_busy), 1);
    reset = 0; #1;
    chk("ar_busy", 32'(div_busy), 0);
    chk("ar_state", 32'(state), 32'(ST_RUN));
    chk("ar_done", 32'(div_done), 0);
    tick(); tick();
    #2 reset = 1;
    done_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      tick(); #2;
      if (div_done || div_busy) done_cnt++;
    end
    chk("ar_no_done", 32'(done_cnt), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter DIV_CYCLES, default 32, divider latency in cycles; legal range 2..63.
REQ-002 Parameter CNT_W, default 6, divide-counter width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-low; asserting it (0) clears all state immediately.
REQ-005 id_rs, id_rt  in  5 each  source register numbers of the instruction in ID.
REQ-006 id_use_rs, id_use_rt  in  1 each  ID instruction actually reads rs / rt.
REQ-007 id_use_hilo  in  1  ID instruction reads HI/LO (mfhi/mflo) or is mult/div.
REQ-008 exe_reg  in  5  destination register of the instruction in EX.
REQ-009 exe_load  in  1  instruction in EX is a load.
REQ-010 div_start  in  1  ID issues a divide this cycle (qualified by no stall).
REQ-011 dmem_req, dmem_ack  in  1 each  data-memory access in MEM and its completion.
REQ-012 exc_req  in  1  exception or interrupt committed in MEM.
REQ-013 stall_if, stall_id, stall_ex, stall_mem  out  1 each  hold the corresponding pipeline register.
REQ-014 bubble_ex  out  1  insert a NOP into the ID/EX register.
REQ-015 flush  out  1  kill IF, ID, EX and MEM contents.
REQ-016 div_busy  out  1  divider is running; div_done  out  1  one-cycle completion pulse.
REQ-017 state  out  2  current FSM state, for debug.

Function
REQ-018 FSM states: RUN=0, DIV_WAIT=1, MEM_WAIT=2, FLUSH=3.
REQ-019 Priority, highest first: exc_req, memory wait, divide interlock, load-use.
REQ-020 exc_req=1 in any state: flush=1 combinationally that cycle; next state FLUSH; any divide is aborted, counter cleared, and no div_done is produced.
REQ-021 FLUSH: all stalls 0, flush 0; next state RUN unconditionally.
REQ-022 dmem_req=1 with dmem_ack=0: all four stall outputs 1 combinationally; state moves to MEM_WAIT.
REQ-023 MEM_WAIT holds all stalls until the cycle dmem_ack=1.
  - In that cycle stalls are 0.
  - Next state is DIV_WAIT if the divide counter is nonzero, otherwise RUN.
REQ-024 The divide counter keeps decrementing during MEM_WAIT; if it reaches 0 there, div_done fires on schedule.
REQ-025 Load-use: exe_load=1, exe_reg!=0, and a used source (id_use_rs/id_use_rt) equals exe_reg.
  - Response: stall_if=stall_id=bubble_ex=1 for exactly that cycle.
  - exe_reg=0 never stalls.
REQ-026 div_start in RUN with no stall: counter loads DIV_CYCLES-1, div_busy=1 next cycle, next state DIV_WAIT.
REQ-027 DIV_WAIT: counter decrements by 1 per cycle. In the cycle it reads 0:
  - div_done=1 and div_busy=0 next.
  - Next state RUN.
  - Total div_busy length is DIV_CYCLES cycles.
REQ-028 While div_busy=1 and id_use_hilo=1: stall_if=stall_id=bubble_ex=1; independent instructions proceed unstalled.
REQ-029 div_done, div_busy and the counter are registered; stall, bubble and flush outputs are combinational from state, counter and inputs.
REQ-030 The counter never underflows; it is not decremented below 0.

Reset
REQ-031 While reset=0:
  - state=RUN and counter=0.
  - div_busy=0 and div_done=0.
  - flush=0 and bubble_ex=0, and all stalls 0 provided dmem_req, exc_req and exe_load are 0.
REQ-032 Reset asserted mid-divide or mid-MEM_WAIT abandons the operation; no div_done follows reset release.

Structure
REQ-033 State encodings and the DIV_CYCLES default go in the shared CPU package, alongside the opcode constants.
REQ-034 Hazard-compare logic (REQ-025) is a sub-module, hazard_detect, that is purely combinational; FSM and counter stay in pipe_ctrl.

Verification
REQ-035 exe_load=1, exe_reg=5, id_rs=5, id_use_rs=1 -> stall_if=stall_id=bubble_ex=1 for one cycle; same stimulus with exe_reg=0 -> no stall.
REQ-036 div_start at cycle 0, DIV_CYCLES=32 -> div_busy=1 on cycles 1..32, div_done=1 on cycle 32; an id_use_hilo at cycle 10 stalls until cycle 32.
REQ-037 dmem_req=1 with ack on cycle 4 -> all stalls 1 on cycles 0..3 and 0 on cycle 4; state returns to RUN.
REQ-038 exc_req at cycle 10 of a divide -> flush=1 that cycle, FLUSH then RUN, div_busy drops, no div_done.
REQ-039 Divide running while MEM_WAIT spans the counter's zero -> div_done is still pulsed exactly at cycle DIV_CYCLES.
REQ-040 reset=0 pulsed asynchronously mid-divide -> outputs clear before the next clock edge; no div_done afterwards.
